// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared constants and helpers for the parametrised up/down counter
package updown_counter_pkg;

  // Direction and boundary-mode encodings
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // All-ones value for a counter of the given width (valid for 1..32)
  function automatic logic [31:0] udc_max_for_width(input int width);
    logic [63:0] full;
    full = (64'd1 << width) - 64'd1;
    return full[31:0];
  endfunction

  // Default counter width and its full-scale maximum
  localparam int          DEFAULT_WIDTH = 8;
  localparam logic [31:0] DEFAULT_MAX   = udc_max_for_width(DEFAULT_WIDTH);

endpackage

// File: rtl/updown_counter_next.sv
// rtl/updown_counter_next.sv - combinational next-count and boundary detection for one enabled step
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] Count,
  input  logic             UpOrDown,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  // One step within [0, max_val]; a count above a lowered bound snaps back to it
  always_comb begin
    next_count = Count;
    boundary   = 1'b0;
    if (UpOrDown == DIR_UP) begin
      if (Count < max_val) begin
        next_count = Count + WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        next_count = (sat_mode == MODE_SAT) ? max_val : '0;
      end
    end else begin
      if (Count > max_val) begin
        next_count = max_val;
      end else if (Count != '0) begin
        next_count = Count - WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        next_count = (sat_mode == MODE_SAT) ? '0 : max_val;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load, bound, wrap/saturate and event pulse; sticky event flag under UDCNT_STICKY_EVT_EN
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             UpOrDown,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             evt_clr,
  output logic [WIDTH-1:0] Count,
  output logic             evt,
  output logic             evt_sticky
);

  localparam logic [WIDTH-1:0] COUNT_MAX   = WIDTH'(udc_max_for_width(WIDTH));
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL) & COUNT_MAX;

  logic [WIDTH-1:0] count_q, count_d;
  logic             evt_q, evt_d;
  logic [WIDTH-1:0] step_count;
  logic             step_boundary;

  updown_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .Count      (count_q),
    .UpOrDown   (UpOrDown),
    .sat_mode   (sat_mode),
    .max_val    (max_val),
    .next_count (step_count),
    .boundary   (step_boundary)
  );

  // Load beats enable beats hold; loads are clamped to the current bound
  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      count_d = step_count;
      evt_d   = step_boundary;
    end
  end

  // Count and event pulse registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_COUNT;
      evt_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
    end
  end

  assign Count = count_q;
  assign evt   = evt_q;

`ifdef UDCNT_STICKY_EVT_EN
  logic sticky_q, sticky_d;

  // A new event sets the flag even when a clear arrives on the same edge
  always_comb begin
    sticky_d = sticky_q;
    if (evt_d) begin
      sticky_d = 1'b1;
    end else if (evt_clr) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky flag register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign evt_sticky = sticky_q;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = evt_clr;
  assign evt_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - self-checking bench for updown_counter_param (WIDTH=4)
module tb_updown_counter_param;

  logic       Clk = 1'b0;
  logic       reset;
  logic       en;
  logic       UpOrDown;
  logic       sat_mode;
  logic [3:0] max_val;
  logic       load;
  logic [3:0] load_val;
  logic       evt_clr;
  logic [3:0] Count;
  logic       evt;
  logic       evt_sticky;

  updown_counter_param #(
    .WIDTH     (4),
    .RESET_VAL (0)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .en         (en),
    .UpOrDown   (UpOrDown),
    .sat_mode   (sat_mode),
    .max_val    (max_val),
    .load       (load),
    .load_val   (load_val),
    .evt_clr    (evt_clr),
    .Count      (Count),
    .evt        (evt),
    .evt_sticky (evt_sticky)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic       sat;
    logic [3:0] mx;
    logic       clr;
    logic [3:0] xc;
    logic       xe;
  } vec_t;

  typedef struct {
    logic [3:0] count;
    logic       evt;
    logic       sticky;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] m_count;
  logic       m_sticky;
  vec_t       tbl[18];

  function automatic vec_t v(input logic ld, input logic [3:0] lv, input logic e, input logic up,
                             input logic sat, input logic [3:0] mx, input logic clr,
                             input logic [3:0] xc, input logic xe);
    vec_t r;
    r.ld = ld; r.lv = lv; r.en = e; r.up = up; r.sat = sat; r.mx = mx; r.clr = clr;
    r.xc = xc; r.xe = xe;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference behaviour of one edge, from the current model count
  task automatic model(input logic ld, input logic [3:0] lv, input logic e, input logic up,
                       input logic sat, input logic [3:0] mx,
                       output logic [3:0] xc, output logic xe);
    xc = m_count;
    xe = 1'b0;
    if (ld) begin
      xc = (lv > mx) ? mx : lv;
    end else if (e) begin
      if (up) begin
        if (m_count < mx) xc = m_count + 4'd1;
        else begin xe = 1'b1; xc = sat ? mx : 4'd0; end
      end else begin
        if (m_count > mx) xc = mx;
        else if (m_count != 4'd0) xc = m_count - 4'd1;
        else begin xe = 1'b1; xc = sat ? 4'd0 : mx; end
      end
    end
  endtask

  task automatic step(input logic ld, input logic [3:0] lv, input logic e, input logic up,
                      input logic sat, input logic [3:0] mx, input logic clr,
                      input logic [3:0] xc, input logic xe, input string tag);
    exp_t x;
    exp_t got;
    @(negedge Clk);
    load = ld; load_val = lv; en = e; UpOrDown = up; sat_mode = sat; max_val = mx; evt_clr = clr;
`ifdef UDCNT_STICKY_EVT_EN
    if (xe) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
`endif
    x.count = xc; x.evt = xe; x.sticky = m_sticky;
    sb.push_back(x);
    m_count = xc;
    @(posedge Clk);
    #1;
    got = sb.pop_front();
    check({tag, ".count"}, 32'(Count), 32'(got.count));
    check({tag, ".evt"}, 32'(evt), 32'(got.evt));
    check({tag, ".sticky"}, 32'(evt_sticky), 32'(got.sticky));
  endtask

  task automatic rstep(input logic ld, input logic [3:0] lv, input logic e, input logic up,
                       input logic sat, input logic [3:0] mx, input logic clr, input string tag);
    logic [3:0] xc;
    logic       xe;
    model(ld, lv, e, up, sat, mx, xc, xe);
    step(ld, lv, e, up, sat, mx, clr, xc, xe, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; UpOrDown = 1'b1; sat_mode = 1'b0; max_val = 4'd9;
    load = 1'b0; load_val = 4'd0; evt_clr = 1'b0;
    m_count = 4'd0; m_sticky = 1'b0;

    // From count 1, max 9: wrap-down, load clamp, runtime bound changes, max_val==0, full scale
    tbl[0]  = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 4'd0,  1'b0);
    tbl[1]  = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 4'd9,  1'b1);
    tbl[2]  = v(1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 4'd9,  1'b0);
    tbl[3]  = v(1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 4'd5,  1'b0);
    tbl[4]  = v(1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 4'd5,  1'b0);
    tbl[5]  = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd6,  1'b0);
    tbl[6]  = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd7,  1'b0);
    tbl[7]  = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd8,  1'b0);
    tbl[8]  = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 4'd0,  1'b1);
    tbl[9]  = v(1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 4'd8,  1'b0);
    tbl[10] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 4'd3,  1'b0);
    tbl[11] = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 4'd3,  1'b1);
    tbl[12] = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1);
    tbl[13] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1);
    tbl[14] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0);
    tbl[15] = v(1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0);
    tbl[16] = v(1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 4'd0,  1'b1);
    tbl[17] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd15, 1'b1);

    #12;
    check("reset.count", 32'(Count), 32'd0);
    check("reset.evt", 32'(evt), 32'd0);
    check("reset.sticky", 32'(evt_sticky), 32'd0);
    @(negedge Clk);
    reset = 1'b1;

    // Wrap-up: 11 edges from 0 with max 9 -> 1..9,0,1; evt only after 9->0
    for (int i = 1; i <= 11; i++)
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 4'(i % 10), (i == 10), "wrap_up");

    for (int i = 0; i < 18; i++)
      step(tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].mx, tbl[i].clr,
           tbl[i].xc, tbl[i].xe, $sformatf("tbl%0d", i));

    // Saturate down from 15 with max 9: snap to 9, run to 0, then hold 0 with evt on 3 edges
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 4'd9, 1'b0, "sat_snap");
    for (int k = 8; k >= 0; k--)
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 4'(k), 1'b0, "sat_down");
    for (int k = 0; k < 3; k++)
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b1, "sat_hold");

    // Async reset mid-count with evt high, no clock edge needed
    step(1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd6, 1'b0, "pre_rst_load");
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 4'd6, 1'b1, "pre_rst_sat");
    @(negedge Clk);
    en = 1'b0; load = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("async_rst.count", 32'(Count), 32'd0);
    check("async_rst.evt", 32'(evt), 32'd0);
    check("async_rst.sticky", 32'(evt_sticky), 32'd0);
    m_count = 4'd0; m_sticky = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, "post_rst_hold");
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 4'd1, 1'b0, "post_rst_up1");
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 4'd2, 1'b0, "post_rst_up2");

    // Sticky flag: set by wrap, held through idle, set wins over clear, clear alone drops it
    step(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0, "stk_load");
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b1, "stk_wrap");
    for (int k = 0; k < 5; k++)
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, "stk_idle");
    step(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0, "stk_load2");
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 4'd0, 1'b1, "stk_clr_wrap");
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, "stk_clr");
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, "stk_after");

    // Random mix against the reference model
    for (int k = 0; k < 60; k++)
      rstep(($urandom_range(7) == 0), 4'($urandom_range(15)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)),
            ($urandom_range(3) == 0), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
